// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, halt opcode and fetch FSM states.
package proc_pkg;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_OP = 9'h1FF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/instr_mem.sv
// Program memory: synchronous single-read/single-write array, registered read, read-before-write.
module instr_mem #(
  parameter int L = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [L-1:0] rd_addr,
  output logic [W-1:0] rd_data,
  input  logic         wr_en,
  input  logic [L-1:0] wr_addr,
  input  logic [W-1:0] wr_data
);
  logic [W-1:0] mem [2**L];

  // Array contents survive reset; only the output register is cleared.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-fetch responder: 1-cycle fetch, jump squash, halt detection, Start/Done sequencing.
module instr_fetch_resp
  import proc_pkg::*;
#(
  parameter int L = PC_W,
  parameter int W = INSTR_W,
  parameter logic [W-1:0] HALT = HALT_OP
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [L-1:0] ProgCtr,
  input  logic         Redirect,
  input  logic         LoadEn,
  input  logic [L-1:0] LoadAddr,
  input  logic [W-1:0] LoadData,
  output logic [W-1:0] Instr,
  output logic [L-1:0] InstrAddr,
  output logic         InstrValid,
  output logic         Done
);
  fetch_state_t state, state_nxt;
  logic         halt_hit;
  logic         wr_en;

  assign halt_hit = InstrValid && (Instr == HALT);
  // Programs may only be rewritten while nothing is executing.
  assign wr_en    = LoadEn && (state != RUN) && !Reset;
  assign Done     = (state == DONE);

  instr_mem #(.L(L), .W(W)) u_mem (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_addr (ProgCtr),
    .rd_data (Instr),
    .wr_en   (wr_en),
    .wr_addr (LoadAddr),
    .wr_data (LoadData)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start)    state_nxt = RUN;
      RUN:     if (halt_hit) state_nxt = DONE;
      DONE:    if (Start)    state_nxt = RUN;
      default:               state_nxt = IDLE;
    endcase
  end

  // Valid tracks the state the fetched word lands in; a taken jump kills the word in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      InstrAddr  <= '0;
      InstrValid <= 1'b0;
    end else begin
      state      <= state_nxt;
      InstrAddr  <= ProgCtr;
      InstrValid <= (state_nxt == RUN) && !Redirect;
    end
  end
endmodule

// File: tb/tb_instr_fetch_resp.sv
// Directed bench for instr_fetch_resp: load, run, squash, blocked load, restart, reset mid-run.
module tb_instr_fetch_resp;
  import proc_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, Start, Redirect, LoadEn;
  logic [9:0] ProgCtr, LoadAddr;
  logic [8:0] LoadData;
  logic [8:0] Instr;
  logic [9:0] InstrAddr;
  logic       InstrValid, Done;

  int tests = 0;
  int fails = 0;

  instr_fetch_resp dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgCtr    (ProgCtr),
    .Redirect   (Redirect),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .Instr      (Instr),
    .InstrAddr  (InstrAddr),
    .InstrValid (InstrValid),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [8:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; Redirect = 1'b0; LoadEn = 1'b0;
    ProgCtr = 10'd3; LoadAddr = '0; LoadData = '0;
    // 1. reset with Start high must be ignored
    tick(); tick();
    check("rst_instr", 16'(Instr), 16'h000);
    check("rst_addr",  16'(InstrAddr), 16'h000);
    check("rst_valid", 16'(InstrValid), 16'h0);
    check("rst_done",  16'(Done), 16'h0);
    check("rst_state", 16'(dut.state), 16'(IDLE));
    Reset = 1'b0; Start = 1'b0; ProgCtr = 10'd0;
    tick();
    check("idle_valid", 16'(InstrValid), 16'h0);

    // 2. load program, then run
    load(10'd0, 9'h011); load(10'd1, 9'h022); load(10'd2, 9'h033); load(10'd3, 9'h1FF);
    load(10'd4, 9'h044); load(10'd5, 9'h1FF); load(10'd6, 9'h066); load(10'd7, 9'h077);
    load(10'd20, 9'h0AA);
    check("load_idle_valid", 16'(InstrValid), 16'h0);
    Start = 1'b1; ProgCtr = 10'd0; tick(); Start = 1'b0;
    check("run0_instr", 16'(Instr), 16'h011);
    check("run0_valid", 16'(InstrValid), 16'h1);
    check("run0_addr",  16'(InstrAddr), 16'h000);
    ProgCtr = 10'd1; tick();
    check("run1_instr", 16'(Instr), 16'h022);
    check("run1_valid", 16'(InstrValid), 16'h1);
    ProgCtr = 10'd2; tick();
    check("run2_instr", 16'(Instr), 16'h033);
    ProgCtr = 10'd3; tick();
    check("run3_instr", 16'(Instr), 16'h1FF);
    check("run3_valid", 16'(InstrValid), 16'h1);
    check("run3_done",  16'(Done), 16'h0);
    ProgCtr = 10'd4; tick();
    check("halt_done",  16'(Done), 16'h1);
    check("halt_valid", 16'(InstrValid), 16'h0);
    check("halt_addr",  16'(InstrAddr), 16'h004);
    ProgCtr = 10'd1; tick();
    check("post_halt_valid", 16'(InstrValid), 16'h0);
    check("post_halt_done",  16'(Done), 16'h1);

    // 3. redirect squashes a HALT word
    Start = 1'b1; ProgCtr = 10'd4; tick(); Start = 1'b0;
    check("restart_done", 16'(Done), 16'h0);
    check("sq4_instr", 16'(Instr), 16'h044);
    check("sq4_valid", 16'(InstrValid), 16'h1);
    ProgCtr = 10'd5; Redirect = 1'b1; tick(); Redirect = 1'b0;
    check("sq5_instr", 16'(Instr), 16'h1FF);
    check("sq5_valid", 16'(InstrValid), 16'h0);
    ProgCtr = 10'd20; tick();
    check("sq20_instr", 16'(Instr), 16'h0AA);
    check("sq20_valid", 16'(InstrValid), 16'h1);
    check("sq20_done",  16'(Done), 16'h0);
    // valid HALT with Redirect in the same cycle: halt wins
    ProgCtr = 10'd5; tick();
    check("hw_valid", 16'(InstrValid), 16'h1);
    Redirect = 1'b1; ProgCtr = 10'd6; tick(); Redirect = 1'b0;
    check("hw_done",  16'(Done), 16'h1);
    check("hw_valid2", 16'(InstrValid), 16'h0);

    // 4. load dropped while in RUN
    Start = 1'b1; ProgCtr = 10'd6; tick(); Start = 1'b0;
    check("blk6_instr", 16'(Instr), 16'h066);
    LoadEn = 1'b1; LoadAddr = 10'd7; LoadData = 9'h155; ProgCtr = 10'd7; tick(); LoadEn = 1'b0;
    check("blk7_instr", 16'(Instr), 16'h077);
    ProgCtr = 10'd5; tick();
    ProgCtr = 10'd7; tick();
    check("blk_done",  16'(Done), 16'h1);
    check("blk_old",   16'(Instr), 16'h077);
    // read-before-write while in DONE
    LoadEn = 1'b1; LoadAddr = 10'd7; LoadData = 9'h155; ProgCtr = 10'd7; tick(); LoadEn = 1'b0;
    check("rbw_old", 16'(Instr), 16'h077);
    tick();
    check("rbw_new", 16'(Instr), 16'h155);

    // 5. restart from DONE
    check("pre_restart_valid", 16'(InstrValid), 16'h0);
    Start = 1'b1; ProgCtr = 10'd0; tick(); Start = 1'b0;
    check("rs_done",  16'(Done), 16'h0);
    check("rs_instr", 16'(Instr), 16'h011);
    check("rs_valid", 16'(InstrValid), 16'h1);
    ProgCtr = 10'd1; tick();
    check("rs1_instr", 16'(Instr), 16'h022);

    // 6. reset mid-run
    Reset = 1'b1; ProgCtr = 10'd2; tick(); Reset = 1'b0;
    check("mr_valid", 16'(InstrValid), 16'h0);
    check("mr_instr", 16'(Instr), 16'h000);
    check("mr_state", 16'(dut.state), 16'(IDLE));
    tick();
    check("mr_idle_valid", 16'(InstrValid), 16'h0);
    // Start and LoadEn together in IDLE: write lands, RUN begins
    Start = 1'b1; LoadEn = 1'b1; LoadAddr = 10'd8; LoadData = 9'h0BB; ProgCtr = 10'd0; tick();
    Start = 1'b0; LoadEn = 1'b0;
    check("sl_instr", 16'(Instr), 16'h011);
    check("sl_valid", 16'(InstrValid), 16'h1);
    ProgCtr = 10'd8; tick();
    check("sl8_instr", 16'(Instr), 16'h0BB);
    check("sl8_valid", 16'(InstrValid), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
